// File: rtl/uart_deframer.sv
// UART receive deframer: oversampled start-bit detection, 7/8-bit LSB-first data,
// optional odd/even parity and one or two stop bits, with a one-cycle valid pulse.
module uart_deframer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_active
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rxS;
  logic [TW-1:0]    tickCnt_q, tickCnt_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             len8_q, len8_d;
  logic [1:0]       parType_q, parType_d;
  logic             twoStop_q, twoStop_d;
  logic             parErr_q, parErr_d;
  logic             frmErr_q, frmErr_d;
  logic [7:0]       dataOut_q, dataOut_d;
  logic             parErrOut_q, parErrOut_d;
  logic             frmErrOut_q, frmErrOut_d;

  logic             midBit;
  logic             sample;
  logic             parityOn;
  logic             lastStop;
  logic             frmErrNext;
  logic [7:0]       rxData;

  assign rxS = sync_q[SYNC_STAGES-1];

  // Start bit is checked half a bit in; afterwards every sample is one full bit later.
  assign midBit     = (state_q == START) ? (tickCnt_q == MID_TICK) : (tickCnt_q == LAST_TICK);
  assign sample     = baud_tick && midBit;
  assign parityOn   = (parType_q == 2'b01) || (parType_q == 2'b10);
  assign rxData     = len8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign lastStop   = !twoStop_q || (bitCnt_q == 4'd1);
  assign frmErrNext = frmErr_q | ~rxS;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      len8_q      <= 1'b0;
      parType_q   <= 2'b00;
      twoStop_q   <= 1'b0;
      parErr_q    <= 1'b0;
      frmErr_q    <= 1'b0;
      dataOut_q   <= '0;
      parErrOut_q <= 1'b0;
      frmErrOut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      len8_q      <= len8_d;
      parType_q   <= parType_d;
      twoStop_q   <= twoStop_d;
      parErr_q    <= parErr_d;
      frmErr_q    <= frmErr_d;
      dataOut_q   <= dataOut_d;
      parErrOut_q <= parErrOut_d;
      frmErrOut_q <= frmErrOut_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tickCnt_d   = tickCnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    len8_d      = len8_q;
    parType_d   = parType_q;
    twoStop_d   = twoStop_q;
    parErr_d    = parErr_q;
    frmErr_d    = frmErr_q;
    dataOut_d   = dataOut_q;
    parErrOut_d = parErrOut_q;
    frmErrOut_d = frmErrOut_q;

    if (baud_tick && state_q != IDLE && state_q != DONE)
      tickCnt_d = midBit ? '0 : tickCnt_q + TW'(1);

    case (state_q)
      IDLE: begin
        // A line that is still low (break or held low) must go high before re-arming.
        if (rxS) armed_d = 1'b1;
        if (baud_tick && armed_q && !rxS) begin
          len8_d    = data_length;
          parType_d = parity_type;
          twoStop_d = stop_bits;
          tickCnt_d = '0;
          bitCnt_d  = '0;
          shift_d   = '0;
          parErr_d  = 1'b0;
          frmErr_d  = 1'b0;
          armed_d   = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (sample) state_d = rxS ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {rxS, shift_q[7:1]};
          if (bitCnt_q == (len8_q ? 4'd7 : 4'd6)) begin
            bitCnt_d = '0;
            state_d  = parityOn ? PARITY : STOP;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          parErr_d = (^rxData) ^ rxS ^ (parType_q == 2'b01);
          state_d  = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          frmErr_d = frmErrNext;
          if (lastStop) begin
            dataOut_d   = rxData;
            parErrOut_d = parErr_q;
            frmErrOut_d = frmErrNext;
            state_d     = DONE;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_out     = dataOut_q;
  assign parity_error = parErrOut_q;
  assign frame_error  = frmErrOut_q;
  assign data_valid   = (state_q == DONE);
  assign rx_active    = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);

endmodule

// File: doc/uart_deframer.md
Name: uart_deframer

Overview:
Receive-side counterpart of the transmit framer. It oversamples the serial line and detects the start bit. It then recovers 7- or 8-bit LSB-first data, an optional odd or even parity bit, and one or two stop bits. It outputs the data with a one-cycle valid pulse plus parity and framing error flags. It sits between the RX pin synchroniser domain and the receive FIFO/host logic, and takes its baud enable from the shared baud generator.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period (power of 2, minimum 8)
SYNC_STAGES, 2, flip-flop stages on rx_in before use

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high
baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate
rx_in  input  1  asynchronous serial line, idle high
data_length  input  1  0 = 7 data bits, 1 = 8 data bits
parity_type  input  2  01 = odd, 10 = even, 00/11 = no parity bit
stop_bits  input  1  0 = 1 stop bit, 1 = 2 stop bits
data_out  output  8  received data; bit 7 = 0 in 7-bit mode
data_valid  output  1  one-clk pulse when a frame completes
parity_error  output  1  parity mismatch on the last completed frame
frame_error  output  1  a stop bit sampled low on the last completed frame
rx_active  output  1  high from start-bit detection until frame completion or abort

Behaviour:
- Reset, synchronous on rst=1: state IDLE, all counters 0, synchroniser flops 1. data_out=0, data_valid=0, parity_error=0, frame_error=0, rx_active=0.
- rst=1 mid-frame discards the partial frame and produces no data_valid.
- rx_in passes through SYNC_STAGES flops. All logic uses the synchronised value rx_s.
- All state advance and sampling occur only on clk edges with baud_tick=1. A tick counter (0..OVERSAMPLE-1) runs within each bit.
- IDLE: waits for rx_s=0, and only after rx_s has been seen 1 at least once since entering IDLE, so a held-low line or break never retriggers.
  - On detection: latch data_length, parity_type and stop_bits into shadow registers, clear the tick counter, set rx_active=1, go to START.
  - Config input changes mid-frame have no effect.
- START: at tick OVERSAMPLE/2-1 (mid-bit) sample rx_s.
  - If 1: false start. Go to IDLE, rx_active=0, no flags changed.
  - If 0: reset the tick counter and go to DATA.
- DATA: sample at mid-bit into a shift register, LSB first. Bit count is 7 or 8 per latched data_length.
  - After the last bit, go to PARITY if parity is enabled (01/10), else go to STOP.
- PARITY: sample at mid-bit. Expected bit is the XOR of received data bits (7 or 8 bits), inverted for odd parity.
  - Odd parity: total ones, data plus parity, is odd. Even parity: total is even.
  - Record the mismatch internally.
- STOP: sample 1 or 2 stop bits at mid-bit. Any stop sample = 0 records a framing error.
  - Transition to DONE occurs on the mid-bit sample of the final stop bit. The receiver does not wait out the rest of the stop bit, so back-to-back frames resync on the next falling edge.
- DONE (one clk, not gated by baud_tick):
  - data_valid=1.
  - data_out = received bits, zero-extended in 7-bit mode.
  - parity_error and frame_error are updated; parity_error is 0 when parity is disabled.
  - rx_active=0, then go to IDLE.
- Latency: data_valid rises on the clk after the baud_tick that samples the final stop bit.
- data_out, parity_error and frame_error hold their values until the next DONE. A frame with errors still produces data_valid.
- Break (line low for a whole frame): frame completes with data_out=0 and frame_error=1. IDLE then requires a return to 1 before re-arming.
- Counter widths: tick counter is $clog2(OVERSAMPLE) bits and wraps to 0 at OVERSAMPLE-1. Bit counter is 4 bits.

Test Plan:
- 8N1, data 0xA5, 16 ticks per bit: data_out=0xA5, data_valid is one pulse, parity_error=0, frame_error=0, rx_active high for about 9.5 bit times.
- 7O2, data 0x35, parity bit 1: data_out=0x35, parity_error=0. Repeat with parity bit 0: parity_error=1, data_valid still pulses.
- 8E1, data 0x0F, parity bit 1 (wrong): parity_error=1. Next correct frame 0x0F with parity 0: parity_error clears to 0.
- 8N1, data 0x3C, stop bit driven 0: frame_error=1, data_out=0x3C. Line then held low: no further data_valid until rx returns high and a new start bit arrives.
- Low glitch of 4 ticks on an idle line: no data_valid, rx_active returns to 0 by mid-start. Then a valid 0x81 frame: data_out=0x81.
- rst pulsed at data bit 3 of a frame: outputs return to reset values, no data_valid for that frame. The following 0x5A frame is received correctly.
